hart_stress_meter: RTL
======================

Name: hart_stress_meter

Overview:
- Producer side of the 3-bit heart-stress `status` bus consumed by the controller's stress-delta logic.
- Takes the raw heartbeat pulse from the sensor front-end and measures the beat-to-beat period in millisecond ticks.
- Averages the last four periods and quantises the result into stress level 0 (rest) to 7 (max).
- Presents the level as a held, glitch-free `status` with a valid flag and an update strobe.

Parameters:
- TICK_DIV, 50000: clk cycles per measurement tick (1 ms at 50 MHz).
- CW, 12: width of the period counter and history entries, in ticks.
- PERIOD_MIN, 250: a beat arriving fewer than this many ticks after the previous accepted beat is a glitch and is ignored.
- TIMEOUT, 2000: ticks without an accepted beat before the sensor is declared lost.
- P_REST, 1000: average period at or above this value gives level 0.
- P_STEP, 100: period step between adjacent levels.
- Constraint: P_REST > 6*P_STEP + PERIOD_MIN.
- Constraint: TIMEOUT > P_REST.
- Constraint: TIMEOUT < 2^CW.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- hartslag  in  1  raw heartbeat pulse, asynchronous to clk, at least 2 clk high per beat.
- status  out  3  stress level 0..7, registered.
- geldig  out  1  high while status reflects a full 4-period average of a live signal.
- nieuw  out  1  one-cycle strobe on every status update.

Behaviour:
- Reset (reset=0, asynchronous):
  - status=0, geldig=0, nieuw=0.
  - Synchroniser flops, tick prescaler, period counter, history, fill count and FSM all return to 0 / IDLE immediately.
  - Applies mid-measurement too; no partial history survives reset.
- Input path:
  - hartslag passes through a 2-flop synchroniser (s1, s2) plus a third flop s3.
  - beat = s2 & ~s3.
  - Let E0 be the clk edge where s1 first samples 1. beat is high during the cycle after E1.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick pulses one cycle at wrap.
  - The prescaler free-runs and is not resynchronised to beats.
- Period counter cnt:
  - Increments on tick and saturates at TIMEOUT.
  - Cleared to 0 on any beat in IDLE and on any accepted beat.
  - A beat takes priority over a tick in the same cycle.
- FSM states: IDLE, MEASURE.
- IDLE:
  - On beat, go to MEASURE with cnt=0 and fill=0.
  - status holds its value; geldig=0.
- MEASURE, beat with cnt < PERIOD_MIN:
  - Beat is ignored; cnt is untouched; no nieuw.
- MEASURE, beat with cnt >= PERIOD_MIN (accepted, at edge E2):
  - cnt is shifted into a 4-entry history (oldest entry dropped).
  - fill increments, saturating at 4.
  - cnt is cleared.
- MEASURE, cnt == TIMEOUT:
  - Go to IDLE; geldig=0 on the same edge; fill=0.
  - status holds its last value, so downstream sees no false drop.
  - If a beat coincides with timeout, timeout wins and that beat is taken as the IDLE first beat: next state MEASURE, cnt=0, fill=0.
- Averaging:
  - sum is CW+2 bits; avg = sum >> 2, truncated.
  - Evaluated only when fill == 4 after a push.
- Quantisation:
  - Thresholds T_k = P_REST - (k-1)*P_STEP for k = 1..7.
  - level = number of k with avg < T_k.
  - Hence avg >= P_REST gives 0 and avg < P_REST - 6*P_STEP gives 7.
- Update (at edge E3, i.e. 3 clk edges after E0):
  - When fill == 4, status <= level, geldig <= 1, and nieuw pulses for exactly one cycle.
  - nieuw fires even if level is unchanged.
  - After the first update, every accepted beat updates status (sliding average).
- No combinational path from hartslag to any output.

Test Plan (TICK_DIV=4, other parameters at default):
1. Hold reset low, then release with hartslag=0 for 5000 clk -> status=0, geldig=0, nieuw never high.
2. Five beats 1000 ticks apart -> after 5th beat, status=0, geldig=1, and nieuw is a single pulse exactly at E0+3. After the 4th beat, geldig is still 0.
3. Five beats 500 ticks apart -> status=5. Then one beat 350 ticks later -> avg=462, status=6, nieuw once. Then three more 350-tick beats -> status=7.
4. Steady 500-tick beats with an extra pulse 100 ticks after a beat -> pulse ignored: no nieuw, status stays 5, next real beat still measured as 500.
5. Valid at status=5, then stop beats -> geldig falls exactly 2000 ticks after the last accepted beat, status stays 5. Restart beats -> geldig returns only after 4 new accepted periods.
6. Assert reset between clk edges mid-measurement -> status, geldig and nieuw go to 0 before the next edge. After release, 4 full periods are required before the first nieuw.

Source files
------------

// File: rtl/hart_stress_meter_if.sv
// Heart-stress status bus between the meter (producer) and the controller
// (consumer).
//   status : stress level 0 (rest) .. 7 (max), held between updates
//   geldig : level is based on a full 4-period average of a live signal
//   nieuw  : one-cycle strobe on every status update
interface hart_stress_meter_if;
  logic [2:0] status;
  logic       geldig;
  logic       nieuw;

  modport master (output status, geldig, nieuw);
  modport slave  (input  status, geldig, nieuw);
endinterface

// File: rtl/hart_stress_meter.sv
// Heartbeat period meter. Measures the beat-to-beat period in ms ticks,
// averages the last four accepted periods and quantises the average into a
// 3-bit stress level on the status bus.
//   clk      : system clock
//   reset    : asynchronous, active-low reset
//   hartslag : raw heartbeat pulse, asynchronous, >= 2 clk high per beat
//   sb       : status bus (status / geldig / nieuw), all registered
module hart_stress_meter #(
  parameter int TICK_DIV   = 50000,
  parameter int CW         = 12,
  parameter int PERIOD_MIN = 250,
  parameter int TIMEOUT    = 2000,
  parameter int P_REST     = 1000,
  parameter int P_STEP     = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hartslag,
  hart_stress_meter_if.master   sb
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                state_q;
  logic                  s1_q, s2_q, s3_q;
  logic [PW-1:0]         pre_q;
  logic [CW-1:0]         cnt_q;
  logic [3:0][CW-1:0]    hist_q;
  logic [2:0]            fill_q;
  logic                  upd_q;
  logic [2:0]            status_q;
  logic                  geldig_q;
  logic                  nieuw_q;

  logic                  beat;
  logic                  tick;
  logic [CW+1:0]         sum;
  logic [CW-1:0]         avg;
  logic [2:0]            level;

  // Rising edge of the synchronised pulse; s3 only serves edge detection.
  assign beat = s2_q & ~s3_q;
  assign tick = (pre_q == PW'(TICK_DIV - 1));

  // Average and level are read one edge after the history push, so the
  // history registers already hold the newest period.
  always_comb begin
    sum   = (CW+2)'(hist_q[0]) + (CW+2)'(hist_q[1])
          + (CW+2)'(hist_q[2]) + (CW+2)'(hist_q[3]);
    avg   = sum[CW+1:2];
    level = 3'd0;
    for (int k = 1; k <= 7; k++)
      if (int'(avg) < P_REST - (k - 1) * P_STEP) level = level + 3'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      pre_q    <= '0;
      cnt_q    <= '0;
      hist_q   <= '0;
      fill_q   <= '0;
      upd_q    <= 1'b0;
      status_q <= 3'd0;
      geldig_q <= 1'b0;
      nieuw_q  <= 1'b0;
    end else begin
      s1_q    <= hartslag;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pre_q   <= tick ? '0 : pre_q + 1'b1;
      upd_q   <= 1'b0;
      nieuw_q <= 1'b0;

      // Free tick counting, saturating; beat clears below override it.
      if (tick && cnt_q != CW'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (beat) begin
            state_q <= MEASURE;
            cnt_q   <= '0;
            fill_q  <= '0;
          end
        end
        MEASURE: begin
          if (cnt_q == CW'(TIMEOUT)) begin
            // Sensor lost; status keeps its last level. A coincident beat
            // restarts measurement as a fresh first beat.
            geldig_q <= 1'b0;
            fill_q   <= '0;
            if (beat) cnt_q <= '0;
            else      state_q <= IDLE;
          end else if (beat && cnt_q >= CW'(PERIOD_MIN)) begin
            hist_q <= {hist_q[2:0], cnt_q};
            cnt_q  <= '0;
            if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
            upd_q  <= (fill_q >= 3'd3);
          end
        end
        default: state_q <= IDLE;
      endcase

      if (upd_q) begin
        status_q <= level;
        geldig_q <= 1'b1;
        nieuw_q  <= 1'b1;
      end
    end
  end

  assign sb.status = status_q;
  assign sb.geldig = geldig_q;
  assign sb.nieuw  = nieuw_q;

endmodule
